store_narrow_rmw: RTL and testbench

Sub-word store unit for the data-memory write path; the inverse of load-side sign/zero extension. Accepts a 32-bit register value with a store size (word/half/byte). Word stores are written directly. Half and byte stores narrow the value to the addressed lane and merge it into the existing word with a read-modify-write sequence, because data memory is word-only. Optionally flags values that do not survive narrowing, i.e. values that re-extension would not reproduce.

---
 rtl/store_narrow_rmw.sv | 167 ++++++++++++++++
 tb/tb_store_narrow_rmw.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: sub-word store unit for a word-only data memory.
// Word stores are written directly. Half and byte stores read the target word,
// merge the addressed little-endian lane and write the word back.
// Optional feature macro: STORE_RANGE_CHECK_EN enables TruncErr, which flags
// values that do not survive narrowing (signed or unsigned per Signed).
module store_narrow_rmw #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [31:0]           write_data_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  output logic                  mem_rd_en_o,
  input  logic [31:0]           mem_rd_data_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  align_err_o,
  output logic                  trunc_err_o
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q;
  logic        half_q;     // 1: half store, 0: byte store (sub-word path only)
  logic [1:0]  lane_q;     // Address[1:0] of the accepted request
  logic [15:0] wdata_q;    // low half of the register value; upper bits never merged
  logic        trunc_q;    // range-check result latched at accept

  logic        misalign_d;
  logic        trunc_d;
  logic [31:0] merged_d;

  // Alignment check on the incoming request (reserved size counts as misaligned)
  always_comb begin
    misalign_d = 1'b0;
    case (size_i)
      SZ_WORD: misalign_d = (address_i[1:0] != 2'b00);
      SZ_HALF: misalign_d = address_i[0];
      SZ_BYTE: misalign_d = 1'b0;
      default: misalign_d = 1'b1;
    endcase
  end

`ifdef STORE_RANGE_CHECK_EN
  // Flag values that re-extension of the narrowed field would not reproduce
  always_comb begin
    trunc_d = 1'b0;
    case (size_i)
      SZ_HALF: trunc_d = signed_i
                         ? !((&write_data_i[31:15]) || (~|write_data_i[31:15]))
                         : (|write_data_i[31:16]);
      SZ_BYTE: trunc_d = signed_i
                         ? !((&write_data_i[31:7]) || (~|write_data_i[31:7]))
                         : (|write_data_i[31:8]);
      default: trunc_d = 1'b0;
    endcase
  end
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign trunc_d       = 1'b0;
`endif

  // Replace only the addressed lane of the read word with the narrowed value
  always_comb begin
    merged_d = mem_rd_data_i;
    if (half_q) begin
      if (lane_q[1]) merged_d[31:16] = wdata_q;
      else           merged_d[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged_d[7:0]   = wdata_q[7:0];
        2'd1:    merged_d[15:8]  = wdata_q[7:0];
        2'd2:    merged_d[23:16] = wdata_q[7:0];
        default: merged_d[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Control FSM; every output is a registered decode of the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      half_q        <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
      trunc_q       <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= 32'h0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      align_err_o   <= 1'b0;
      trunc_err_o   <= 1'b0;
    end else begin
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      done_o      <= 1'b0;
      align_err_o <= 1'b0;
      trunc_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            mem_addr_o <= {address_i[ADDR_WIDTH-1:2], 2'b00};
            half_q     <= (size_i == SZ_HALF);
            lane_q     <= address_i[1:0];
            wdata_q    <= write_data_i[15:0];
            trunc_q    <= trunc_d;
            busy_o     <= 1'b1;
            if (misalign_d) begin
              state_q     <= S_ERR;
              done_o      <= 1'b1;
              align_err_o <= 1'b1;
            end else if (size_i == SZ_WORD) begin
              state_q       <= S_WR;
              mem_wr_en_o   <= 1'b1;
              mem_wr_data_o <= write_data_i;
              done_o        <= 1'b1;
            end else begin
              state_q     <= S_RD;
              mem_rd_en_o <= 1'b1;
            end
          end
        end
        S_RD: begin
          state_q <= S_WAIT;
          busy_o  <= 1'b1;
        end
        S_WAIT: begin
          state_q       <= S_WR;
          busy_o        <= 1'b1;
          mem_wr_data_o <= merged_d;
          mem_wr_en_o   <= 1'b1;
          done_o        <= 1'b1;
          trunc_err_o   <= trunc_q;
        end
        S_WR, S_ERR: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Testbench for store_narrow_rmw: vector table plus reset and busy-start sequences.
module tb_store_narrow_rmw;

`ifdef STORE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  size;
  logic        sgn;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        align_err;
  logic        trunc_err;

  store_narrow_rmw #(.ADDR_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .address_i    (address),
    .write_data_i (write_data),
    .size_i       (size),
    .signed_i     (sgn),
    .mem_rd_en_o  (mem_rd_en),
    .mem_rd_data_i(mem_rd_data),
    .mem_wr_en_o  (mem_wr_en),
    .mem_addr_o   (mem_addr),
    .mem_wr_data_o(mem_wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .align_err_o  (align_err),
    .trunc_err_o  (trunc_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rd;
    logic [31:0] exp_wd;
    logic        exp_wr;
    logic        exp_align;
    logic        exp_trunc;   // result with range check enabled
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        wr;
    logic        rd;
    logic        align;
    logic        trunc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] cur_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid only in the cycle after the read strobe
  always @(posedge clk) mem_rd_data <= mem_rd_en ? cur_rd : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Drive one request, push its expectation, then watch cycle by cycle until Done.
  task automatic run(input vec_t v, input bit poke);
    exp_t e;
    exp_t g;
    int   rdc;
    int   wrc;
    bit   got;
    @(negedge clk);
    address    = v.addr;
    write_data = v.wd;
    size       = v.size;
    sgn        = v.sgn;
    cur_rd     = v.rd;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    e.addr  = {v.addr[31:2], 2'b00};
    e.wd    = v.exp_wd;
    e.wr    = v.exp_wr;
    e.align = v.exp_align;
    e.trunc = v.exp_trunc & RC;
    e.rd    = v.exp_wr && (v.size != 2'b00);
    e.lat   = (v.exp_wr && (v.size != 2'b00)) ? 3 : 1;
    e.acc   = cyc;
    sb.push_back(e);
    rdc = 0;
    wrc = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (poke) begin
        start      = (i < 2);
        address    = 32'h0000_0500;
        write_data = 32'h5555_5555;
        size       = 2'b00;
      end
      if (mem_rd_en) rdc++;
      if (mem_wr_en) wrc++;
      if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 32'(1), 32'(0));
      if (!done && (align_err || trunc_err)) chk("err_without_done", 32'({align_err, trunc_err}), 32'(0));
      if (!busy) chk("busy_in_flight", 32'(busy), 32'(1));
      if (done) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          g = sb.pop_front();
          chk("mem_addr", mem_addr, g.addr);
          chk("wr_en", 32'(mem_wr_en), 32'(g.wr));
          if (g.wr) chk("wr_data", mem_wr_data, g.wd);
          chk("align_err", 32'(align_err), 32'(g.align));
          chk("trunc_err", 32'(trunc_err), 32'(g.trunc));
          chk("latency", 32'(cyc - g.acc + 1), 32'(g.lat));
          chk("rd_count", 32'(rdc), 32'(g.rd));
          chk("wr_count", 32'(wrc), 32'(g.wr));
        end
      end
    end
    if (!got) chk("done_timeout", 32'(0), 32'(1));
    start = 1'b0;
    @(negedge clk);
    chk("post_done_idle", 32'({busy, done, mem_wr_en, mem_rd_en}), 32'(0));
    chk("sb_drained", 32'(sb.size()), 32'(0));
  endtask

  vec_t vecs[12];
  vec_t rv;

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    cur_rd     = 32'h0;
    rst        = 1'b1;
    start      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    size       = 2'b00;
    sgn        = 1'b0;

    //             addr          wd            size   sgn   rd            exp_wd        wr    align trunc
    vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0202, 32'h0000_00A5, 2'b10, 1'b0, 32'h1122_3344, 32'h11A5_3344, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0206, 32'hFFFF_8001, 2'b01, 1'b1, 32'h1122_3344, 32'h8001_3344, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0206, 32'hFFFF_8001, 2'b01, 1'b0, 32'h1122_3344, 32'h8001_3344, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0301, 32'h0000_1234, 2'b01, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0400, 32'h0000_1234, 2'b11, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0102, 32'h0000_1234, 2'b00, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0203, 32'h0000_01FF, 2'b10, 1'b0, 32'hAABB_CCDD, 32'hFFBB_CCDD, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_0200, 32'hFFFF_FF80, 2'b10, 1'b1, 32'h1234_5678, 32'h1234_5680, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0201, 32'h0000_0080, 2'b10, 1'b1, 32'h1234_5678, 32'h1234_8078, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{32'h0000_0204, 32'h0000_FFFF, 2'b01, 1'b0, 32'hCAFE_F00D, 32'hCAFE_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'b00, 1'b1, 32'h0,        32'h1234_5678, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({mem_rd_en, mem_wr_en, busy, done, align_err, trunc_err}), 32'(0));
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wr_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run(vecs[i], 1'b0);

    // Start pulses during RD and WAIT of a byte store must be ignored
    rv = '{32'h0000_0209, 32'h0000_003C, 2'b10, 1'b0, 32'h0102_0304, 32'h0102_3C04, 1'b1, 1'b0, 1'b0};
    run(rv, 1'b1);

    // Reset asserted in WAIT: outputs clear at once and no write follows
    @(negedge clk);
    address    = 32'h0000_0208;
    write_data = 32'h0000_0077;
    size       = 2'b10;
    sgn        = 1'b0;
    cur_rd     = 32'hFFFF_FFFF;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_seq_rd_en", 32'(mem_rd_en), 32'(1));
    @(negedge clk);
    chk("rst_seq_in_wait", 32'({mem_rd_en, mem_wr_en, busy}), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({mem_rd_en, mem_wr_en, busy, done, align_err, trunc_err}), 32'(0));
    chk("async_reset_addr", mem_addr, 32'h0);
    chk("async_reset_wdata", mem_wr_data, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("no_write_in_reset", 32'({mem_wr_en, done}), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({mem_wr_en, done, busy}), 32'(0));
    rv = '{32'h0000_0600, 32'hA5A5_5A5A, 2'b00, 1'b0, 32'h0, 32'hA5A5_5A5A, 1'b1, 1'b0, 1'b0};
    run(rv, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
